vga_timing_sequencer: RTL

- Run/stop controller for the VGA raster in the bouncing-logo design. Owns the pixel-enable divider and the chained horizontal and vertical pixel counters.
- Produces sync, blanking, pixel coordinates and frame/line strobes for the logo renderer and the motion logic.
- Stop requests are frame-aligned, so the monitor never sees a truncated frame.

---
 rtl/vga_timing_sequencer.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/vga_timing_sequencer.sv
// Run/stop raster timing for the bouncing-logo VGA path: pixel-enable divider,
// chained pixel counters, and registered sync/blank/strobe outputs.
module vga_timing_sequencer #(
  parameter int H_VISIBLE = 640,
  parameter int H_FP      = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BP      = 48,
  parameter int V_VISIBLE = 480,
  parameter int V_FP      = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BP      = 33,
  parameter int CLK_DIV   = 2,
  parameter bit SYNC_POL  = 1'b0,
  parameter int CW        = 10
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          run,
  output logic          pixel_tick,
  output logic          hsync,
  output logic          vsync,
  output logic          video_on,
  output logic [CW-1:0] pixel_x,
  output logic [CW-1:0] pixel_y,
  output logic          line_start,
  output logic          frame_start,
  output logic          running
);

  localparam int H_TOTAL = H_VISIBLE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_VISIBLE + V_FP + V_SYNC + V_BP;
  localparam int DW      = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [DW-1:0] DIV_MAX  = DW'(CLK_DIV - 1);
  localparam logic [CW-1:0] H_MAX    = CW'(H_TOTAL - 1);
  localparam logic [CW-1:0] V_MAX    = CW'(V_TOTAL - 1);
  localparam logic [CW-1:0] H_VIS    = CW'(H_VISIBLE);
  localparam logic [CW-1:0] V_VIS    = CW'(V_VISIBLE);
  localparam logic [CW-1:0] HS_FIRST = CW'(H_VISIBLE + H_FP);
  localparam logic [CW-1:0] HS_LAST  = CW'(H_VISIBLE + H_FP + H_SYNC - 1);
  localparam logic [CW-1:0] VS_FIRST = CW'(V_VISIBLE + V_FP);
  localparam logic [CW-1:0] VS_LAST  = CW'(V_VISIBLE + V_FP + V_SYNC - 1);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    RUN      = 2'd1,
    STOPPING = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [DW-1:0]   div_cnt_q, div_cnt_d;
  logic [CW-1:0]   pixel_x_q, pixel_x_d;
  logic [CW-1:0]   pixel_y_q, pixel_y_d;
  logic            pixel_tick_q, pixel_tick_d;
  logic            hsync_q, hsync_d;
  logic            vsync_q, vsync_d;
  logic            video_on_q, video_on_d;
  logic            line_start_q, line_start_d;
  logic            frame_start_q, frame_start_d;
  logic            running_q, running_d;

  logic tick;
  logic frame_end;
  logic new_pos;
  logic active;

  always_comb begin
    state_d   = state_q;
    div_cnt_d = div_cnt_q;
    pixel_x_d = pixel_x_q;
    pixel_y_d = pixel_y_q;
    new_pos   = 1'b0;
    tick      = (state_q != IDLE) && (div_cnt_q == DIV_MAX);
    frame_end = (pixel_x_q == H_MAX) && (pixel_y_q == V_MAX);

    // A pending stop only lands on the last tick of a frame, and a re-raised run wins there.
    case (state_q)
      IDLE:     if (run) state_d = RUN;
      RUN:      if (!run) state_d = STOPPING;
      STOPPING: begin
        if (run)                    state_d = RUN;
        else if (tick && frame_end) state_d = IDLE;
      end
      default:  state_d = IDLE;
    endcase

    if (state_q == IDLE) begin
      div_cnt_d = '0;
      pixel_x_d = '0;
      pixel_y_d = '0;
      new_pos   = (state_d == RUN);
    end else if (state_d == IDLE) begin
      div_cnt_d = '0;
      pixel_x_d = '0;
      pixel_y_d = '0;
    end else begin
      div_cnt_d = tick ? '0 : div_cnt_q + DW'(1);
      if (tick) begin
        new_pos = 1'b1;
        if (pixel_x_q == H_MAX) begin
          pixel_x_d = '0;
          pixel_y_d = (pixel_y_q == V_MAX) ? '0 : pixel_y_q + CW'(1);
        end else begin
          pixel_x_d = pixel_x_q + CW'(1);
        end
      end
    end

    // Decode from the next counts so the registered outputs line up with pixel_x/pixel_y.
    active        = (state_d != IDLE);
    running_d     = active;
    pixel_tick_d  = active && (div_cnt_d == DIV_MAX);
    line_start_d  = new_pos && (pixel_x_d == '0);
    frame_start_d = new_pos && (pixel_x_d == '0) && (pixel_y_d == '0);
    video_on_d    = active && (pixel_x_d < H_VIS) && (pixel_y_d < V_VIS);
    hsync_d       = (active && (pixel_x_d >= HS_FIRST) && (pixel_x_d <= HS_LAST))
                    ? SYNC_POL : ~SYNC_POL;
    vsync_d       = (active && (pixel_y_d >= VS_FIRST) && (pixel_y_d <= VS_LAST))
                    ? SYNC_POL : ~SYNC_POL;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      div_cnt_q     <= '0;
      pixel_x_q     <= '0;
      pixel_y_q     <= '0;
      pixel_tick_q  <= 1'b0;
      hsync_q       <= ~SYNC_POL;
      vsync_q       <= ~SYNC_POL;
      video_on_q    <= 1'b0;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
      running_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      div_cnt_q     <= div_cnt_d;
      pixel_x_q     <= pixel_x_d;
      pixel_y_q     <= pixel_y_d;
      pixel_tick_q  <= pixel_tick_d;
      hsync_q       <= hsync_d;
      vsync_q       <= vsync_d;
      video_on_q    <= video_on_d;
      line_start_q  <= line_start_d;
      frame_start_q <= frame_start_d;
      running_q     <= running_d;
    end
  end

  assign pixel_tick  = pixel_tick_q;
  assign hsync       = hsync_q;
  assign vsync       = vsync_q;
  assign video_on    = video_on_q;
  assign pixel_x     = pixel_x_q;
  assign pixel_y     = pixel_y_q;
  assign line_start  = line_start_q;
  assign frame_start = frame_start_q;
  assign running     = running_q;

endmodule
